remote_cmd_seq: RTL

REMOTE_CMD_SEQ -- requirements
Module: remote_cmd_seq

---
 rtl/remote_pkg.sv | 18 +
 rtl/cmd_fifo.sv | 58 +++++
 rtl/remote_cmd_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/remote_pkg.sv
// Shared types and constants for the remote command sequencer.
package remote_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_SENT,
    WAIT_RESP
  } state_t;

  localparam logic [7:0] ACK = 8'hA5;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] data;
  } entry_t;

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead command FIFO: head always presents the oldest entry while non-empty.
module cmd_fifo
  import remote_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Fullness is judged before any same-cycle pop, so a push on a full queue is dropped.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/remote_cmd_seq.sv
// Queues {cmd,data} entries and drives them one at a time through RemoteComm,
// retrying on NAK or response timeout and abandoning after MAX_RETRY resends.
module remote_cmd_seq
  import remote_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int unsigned TIMEOUT   = 20'd1_000_000,
  parameter int          MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  push_cmd,
  input  logic [15:0] push_data,
  output logic        full,
  output logic        ovf,
  output logic        snd_cmd,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        clr_resp_rdy,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  err_cmd
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_ONE = RW'(1);

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [RW-1:0] retry_cnt;
  entry_t        push_entry;
  entry_t        head;
  logic          empty;
  logic          pop;
  logic          ack_hit;
  logic          abandon;
  logic          resend;
  logic          failed;

  assign push_entry = {push_cmd, push_data};

  cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (push_entry),
    .pop  (pop && !rst),
    .head (head),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      retry_cnt <= '0;
      err_cmd   <= '0;
    end else begin
      state <= state_nxt;
      if (state == WAIT_RESP) tmo_cnt <= tmo_cnt + TMO_ONE;
      else                    tmo_cnt <= '0;
      if (state == IDLE) retry_cnt <= '0;
      else if (resend)   retry_cnt <= retry_cnt + RETRY_ONE;
      if (abandon) err_cmd <= head.cmd;
    end
  end

  // A response present on the timeout cycle is judged on its content, not as a timeout.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    ack_hit   = 1'b0;
    abandon   = 1'b0;
    resend    = 1'b0;
    failed    = 1'b0;
    case (state)
      IDLE:      if (!empty) state_nxt = SEND;
      SEND:      state_nxt = WAIT_SENT;
      WAIT_SENT: if (cmd_sent) state_nxt = WAIT_RESP;
      WAIT_RESP: begin
        failed = resp_rdy ? (resp != ACK) : (tmo_cnt == TMO_LAST);
        if (failed) begin
          if (retry_cnt < RETRY_MAX) begin
            resend    = 1'b1;
            state_nxt = SEND;
          end else begin
            abandon   = 1'b1;
            pop       = 1'b1;
            state_nxt = IDLE;
          end
        end else if (resp_rdy) begin
          ack_hit   = 1'b1;
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  assign snd_cmd      = !rst && (state == SEND);
  assign clr_resp_rdy = !rst && (state == WAIT_RESP) && resp_rdy;
  assign done         = !rst && ack_hit;
  assign err          = !rst && abandon;
  assign ovf          = !rst && push && full;
  assign busy         = !rst && ((state != IDLE) || !empty);
  assign cmd          = (!rst && state != IDLE) ? head.cmd  : '0;
  assign data         = (!rst && state != IDLE) ? head.data : '0;

endmodule
